// File: rtl/col_reduce_pkg.sv
// Shared definitions for the ALU stage and the column reducer downstream of it.
package col_reduce_pkg;

  localparam int NUM_SIZE  = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } reduce_state_t;

endpackage

// File: rtl/col_reduce_if.sv
// Element stream in, per-column aggregate out, each under valid/ready.
interface col_reduce_if #(
   parameter int NUM_SIZE = col_reduce_pkg::NUM_SIZE,
   parameter int CNT_W    = col_reduce_pkg::CNT_W_DEF
);
   localparam int SUM_W = NUM_SIZE + CNT_W;

   logic                       in_valid;
   logic signed [NUM_SIZE-1:0] in_data;
   logic                       in_last;
   logic                       in_ready;
   logic                       out_valid;
   logic                       out_ready;
   logic signed [SUM_W-1:0]    out_sum;
   logic signed [NUM_SIZE-1:0] out_min;
   logic signed [NUM_SIZE-1:0] out_max;
   logic [CNT_W-1:0]           out_count;
   logic                       out_trunc;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_min, out_max, out_count, out_trunc
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_min, out_max, out_count, out_trunc
   );
endinterface

// File: rtl/col_reduce_update.sv
// Combinational accumulator step: folds one element into sum/min/max/count,
// or starts a fresh column when first is set.
module reduce_update #(
   parameter int NUM_SIZE = col_reduce_pkg::NUM_SIZE,
   parameter int CNT_W    = col_reduce_pkg::CNT_W_DEF,
   parameter int SUM_W    = NUM_SIZE + CNT_W
) (
   input  logic                       first,
   input  logic signed [NUM_SIZE-1:0] data,
   input  logic signed [SUM_W-1:0]    sum,
   input  logic signed [NUM_SIZE-1:0] min,
   input  logic signed [NUM_SIZE-1:0] max,
   input  logic [CNT_W-1:0]           cnt,
   output logic signed [SUM_W-1:0]    sum_nxt,
   output logic signed [NUM_SIZE-1:0] min_nxt,
   output logic signed [NUM_SIZE-1:0] max_nxt,
   output logic [CNT_W-1:0]           cnt_nxt
);
   logic signed [SUM_W-1:0] data_ext;

   assign data_ext = {{CNT_W{data[NUM_SIZE-1]}}, data};

   always_comb begin
      sum_nxt = data_ext;
      min_nxt = data;
      max_nxt = data;
      cnt_nxt = CNT_W'(1);
      if (!first) begin
         sum_nxt = sum + data_ext;
         min_nxt = (data < min) ? data : min;
         max_nxt = (data > max) ? data : max;
         cnt_nxt = cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/col_reduce.sv
// Streaming column reducer: sum/min/max/count per in_last-delimited column,
// result held in registers until the consumer takes it.
module col_reduce #(
   parameter int NUM_SIZE = col_reduce_pkg::NUM_SIZE,
   parameter int CNT_W    = col_reduce_pkg::CNT_W_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   col_reduce_if.slave  bus
);
   import col_reduce_pkg::*;

   localparam int SUM_W = NUM_SIZE + CNT_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   reduce_state_t              state, state_nxt;
   logic signed [SUM_W-1:0]    sum_q, sum_nxt;
   logic signed [NUM_SIZE-1:0] min_q, min_nxt, max_q, max_nxt;
   logic [CNT_W-1:0]           cnt_q, cnt_nxt;
   logic                       trunc_q;
   logic                       first, accept, take, sat, close;

   assign bus.in_ready  = (state != DONE) || bus.out_ready;
   assign bus.out_valid = (state == DONE);
   assign take   = bus.out_valid && bus.out_ready;
   assign accept = bus.in_valid && bus.in_ready && !clear;
   // In DONE a beat is only accepted alongside the handshake, so it opens a new column.
   assign first  = (state != ACCUM);
   assign sat    = (cnt_nxt == CNT_MAX);
   assign close  = bus.in_last || sat;

   reduce_update #(.NUM_SIZE(NUM_SIZE), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_update (
      .first   (first),
      .data    (bus.in_data),
      .sum     (sum_q),
      .min     (min_q),
      .max     (max_q),
      .cnt     (cnt_q),
      .sum_nxt (sum_nxt),
      .min_nxt (min_nxt),
      .max_nxt (max_nxt),
      .cnt_nxt (cnt_nxt)
   );

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE, ACCUM: if (accept) state_nxt = close ? DONE : ACCUM;
            DONE: if (take) state_nxt = accept ? (close ? DONE : ACCUM) : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // The accumulators double as the result registers once the column closes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
         cnt_q   <= '0;
         trunc_q <= 1'b0;
      end else if (clear) begin
         sum_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
         cnt_q   <= '0;
         trunc_q <= 1'b0;
      end else if (accept) begin
         sum_q   <= sum_nxt;
         min_q   <= min_nxt;
         max_q   <= max_nxt;
         cnt_q   <= cnt_nxt;
         trunc_q <= sat && !bus.in_last;
      end
   end

   assign bus.out_sum   = sum_q;
   assign bus.out_min   = min_q;
   assign bus.out_max   = max_q;
   assign bus.out_count = cnt_q;
   assign bus.out_trunc = trunc_q;
endmodule

// File: tb/tb_col_reduce.sv
// Scoreboard bench for col_reduce: directed columns plus randomized streams
// against a queue-based column model; CNT_W is 4 to reach counter saturation.
module tb_col_reduce;
   localparam int NS   = 32;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      longint sum;
      longint min;
      longint max;
      longint count;
      longint trunc;
   } res_t;

   logic clk = 1'b0;
   logic reset_n;
   logic clear;
   int   checks = 0;
   int   fails  = 0;
   bit   rnd_rdy = 0;
   res_t sb[$];
   longint cur[$];

   col_reduce_if #(.NUM_SIZE(NS), .CNT_W(CW)) bus ();

   col_reduce #(.NUM_SIZE(NS), .CNT_W(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Column model: collect accepted elements, aggregate when the column closes.
   function automatic void model_accept(longint d, bit last);
      res_t r;
      cur.push_back(d);
      if (last || cur.size() == CMAX) begin
         r.sum = 0; r.min = cur[0]; r.max = cur[0];
         foreach (cur[i]) begin
            r.sum += cur[i];
            if (cur[i] < r.min) r.min = cur[i];
            if (cur[i] > r.max) r.max = cur[i];
         end
         r.count = cur.size();
         r.trunc = last ? 0 : 1;
         sb.push_back(r);
         cur.delete();
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_rdy) bus.out_ready = ($urandom % 4) != 0;
   endtask

   task automatic beat(input logic signed [NS-1:0] d, input bit last);
      bit ok;
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      forever begin
         @(negedge clk);
         ok = bus.in_ready;
         step();
         if (ok) break;
         n++;
         if (n > 200) begin
            checks++; fails++;
            $display("FAIL beat_timeout: got no in_ready expected in_ready within 200 cycles");
            break;
         end
      end
      if (ok) model_accept(longint'(d), last);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      repeat (n) step();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      cur.delete();
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         step();
         n++;
      end
      chk("drain_pending", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      res_t e;
      if (reset_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("sum",   longint'(bus.out_sum), e.sum);
            chk("min",   longint'(bus.out_min), e.min);
            chk("max",   longint'(bus.out_max), e.max);
            chk("count", longint'(bus.out_count), e.count);
            chk("trunc", longint'(bus.out_trunc), e.trunc);
         end
      end
   end

   initial begin
      longint h_sum, h_cnt;
      logic signed [NS-1:0] d;
      int len;
      reset_n = 1'b0; clear = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_sum", longint'(bus.out_sum), 0);
      chk("rst_count", bus.out_count, 0);
      reset_n = 1'b1;
      step();

      // {5,-3,12,0}L: valid for exactly one cycle
      beat(5, 0); beat(-3, 0); beat(12, 0); beat(0, 1);
      bus.in_valid = 1'b0;
      chk("t1_valid_rise", bus.out_valid, 1);
      step();
      chk("t1_valid_fall", bus.out_valid, 0);

      beat(32'sh8000_0000, 1);
      idle(2);

      // Stall after {1,2}L, then 7L rides the handshake cycle
      bus.out_ready = 1'b0;
      beat(1, 0); beat(2, 1);
      bus.in_valid = 1'b0;
      h_sum = bus.out_sum; h_cnt = bus.out_count;
      repeat (3) begin
         chk("stall_in_ready", bus.in_ready, 0);
         chk("stall_sum_hold", longint'(bus.out_sum), h_sum);
         chk("stall_cnt_hold", bus.out_count, h_cnt);
         step();
      end
      bus.out_ready = 1'b1;
      beat(7, 1);
      bus.in_valid = 1'b0;
      chk("b2b_valid", bus.out_valid, 1);
      chk("b2b_count", bus.out_count, 1);
      idle(2);

      // Saturation: 16 beats of +1 with no last
      for (int i = 0; i < 16; i++) beat(1, 0);
      bus.in_valid = 1'b0;
      chk("sat_new_count", bus.out_count, 1);
      chk("sat_new_valid", bus.out_valid, 0);
      beat(1, 1);
      idle(1);
      drain();

      // Clear mid-column; a beat presented with clear is dropped
      beat(9, 0); beat(9, 0);
      bus.in_valid = 1'b1; bus.in_data = 100; bus.in_last = 1'b1;
      pulse_clear();
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      chk("clr_valid", bus.out_valid, 0);
      beat(4, 1);
      idle(2);
      drain();

      // Clear discards a pending result
      bus.out_ready = 1'b0;
      beat(8, 1);
      idle(1);
      chk("pend_valid", bus.out_valid, 1);
      pulse_clear();
      void'(sb.pop_back());
      chk("pend_cleared_valid", bus.out_valid, 0);
      chk("pend_cleared_sum", longint'(bus.out_sum), 0);
      bus.out_ready = 1'b1;

      // Random columns with random backpressure and gaps
      rnd_rdy = 1;
      for (int c = 0; c < 40; c++) begin
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            case ($urandom % 8)
               0: d = 32'sh8000_0000;
               1: d = 32'sh7fff_ffff;
               default: d = $signed($urandom);
            endcase
            beat(d, i == len - 1);
            if ($urandom % 4 == 0) idle($urandom_range(1, 2));
         end
      end
      rnd_rdy = 0;
      bus.out_ready = 1'b1;
      idle(1);
      drain();

      // Async reset while a result is held
      bus.out_ready = 1'b0;
      beat(3, 1);
      idle(1);
      chk("prerst_valid", bus.out_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      void'(sb.pop_back());
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_in_ready", bus.in_ready, 1);
      chk("arst_sum", longint'(bus.out_sum), 0);
      chk("arst_min", longint'(bus.out_min), 0);
      chk("arst_max", longint'(bus.out_max), 0);
      chk("arst_count", bus.out_count, 0);
      chk("arst_trunc", bus.out_trunc, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      step();
      chk("final_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/col_reduce.md
# col_reduce

Streaming column reducer that sits directly downstream of the element-wise ALU stage (`dut`). It consumes that stage's valid/result stream one signed element per beat and produces, per column, the sum, minimum, maximum and element count, which the host reads back as a pandas-style aggregate. Columns are delimited by an `in_last` flag. Results are held under a valid/ready handshake until the consumer accepts them.

## Interface
Parameters:
- `NUM_SIZE`, default from the shared definitions package: element width, signed.
- `CNT_W`, default 16: element-counter width; maximum column length is 2**CNT_W-1.
- `SUM_W`, localparam = NUM_SIZE+CNT_W: accumulator width, overflow-free by construction.

Ports:
- `clk`  in  1  sole clock; all state is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; there is one clock, and this reset is asynchronous and active-low.
- `clear`  in  1  synchronous abort; discards any partial column.
- `in_valid`  in  1  element beat present; driven from the ALU's `valid`.
- `in_data`  in  NUM_SIZE  signed element; driven from the ALU's `out`.
- `in_last`  in  1  marks the final element of the column; qualified by `in_valid`.
- `in_ready`  out  1  block accepts a beat this cycle.
- `out_valid`  out  1  result registers hold a completed column.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  SUM_W  signed sum of the column.
- `out_min`, `out_max`  out  NUM_SIZE  signed extrema.
- `out_count`  out  CNT_W  number of elements in the column (≥1).
- `out_trunc`  out  1  column was closed by counter saturation, not by `in_last`.

## Operation
- A beat is accepted when `in_valid && in_ready`. A result is taken when `out_valid && out_ready`.
- States: IDLE (no partial column), ACCUM (≥1 element held), DONE (result presented).
- `in_ready` = (state != DONE) || `out_ready`. `out_valid` = (state == DONE).
- First beat of a column, taken from IDLE or from DONE with the result handshake in the same cycle:
  - sum = sign-extended `in_data`; min = max = `in_data`; count = 1; trunc = 0.
- Each subsequent beat:
  - sum += sign-extended `in_data`; count += 1.
  - min/max updated by signed compare. Ties keep the existing value, which is numerically identical.
- Transitions:
  - IDLE→ACCUM on an accepted beat without last.
  - IDLE→DONE on an accepted beat with last.
  - ACCUM→DONE on an accepted beat with `in_last`, or when the accepted beat makes count = 2**CNT_W-1. In the saturation case `out_trunc` = 1 unless `in_last` is also set.
  - DONE→IDLE on handshake with no beat.
  - DONE→ACCUM or DONE (new column) on handshake plus a beat in the same cycle. The old result is consumed and the new column begins with no bubble.
- `clear` takes priority over all handshakes:
  - State→IDLE; result and accumulator registers zeroed.
  - A beat presented that cycle is dropped, and a pending result is discarded.
- `in_valid` low in ACCUM simply holds state. There is no timeout.

## Timing
- Async reset: state IDLE. `out_valid`, `out_sum`, `out_min`, `out_max`, `out_count` and `out_trunc` are 0. `in_ready` is 1 (IDLE).
- Throughput is one element per cycle, including back-to-back columns when `out_ready` is held high.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted. Outputs are registered and stable while `out_valid && !out_ready`.
- Reset mid-column drops the column and produces no result. Deassertion is synchronised externally. The first edge after release may accept a beat.
- Overflow: |sum| ≤ (2**CNT_W-1)·2**(NUM_SIZE-1) < 2**(SUM_W-1). No saturation logic is needed on the sum.

## Structure
- Shared package (alongside `NUM_SIZE` and the opcodes): a `reduce_state_t` enum {IDLE, ACCUM, DONE}, plus the default `CNT_W` constant.
- One sub-module, `reduce_update`: purely combinational. It takes the current accumulators, the beat and a first-beat flag, and returns the next sum/min/max/count. `col_reduce` holds the FSM, registers and handshake.

## Test plan
- Column {5, -3, 12, 0} with last on 0, `out_ready` = 1 → one cycle after the last beat: sum 14, min -3, max 12, count 4, trunc 0; `out_valid` high for exactly one cycle.
- Single-element column {-2147483648} with last (NUM_SIZE = 32) → sum -2147483648 sign-extended, min = max = -2147483648, count 1.
- Back-to-back columns {1, 2}L {7}L, with `out_ready` low for 3 cycles after the first result → `in_ready` 0 during the stall. The first result (3, 1, 2, 2) is held stable. The handshake cycle accepts 7, and the next result is (7, 7, 7, 1) with no bubble.
- CNT_W = 4, feed 16 beats of +1 with no last → after beat 15: sum 15, count 15, trunc 1. Beat 16 starts a new column (count 1).
- Assert `clear` mid-column after {9, 9}, then feed {4}L → result is sum 4, count 1. The pulled-back column never appears.
- Assert `reset_n` low while in DONE with `out_ready` low → all outputs read 0 asynchronously and `in_ready` = 1.
